divider: RTL and testbench

Sequential 32-bit signed integer divider: the inverse datapath to the Booth multiplier in the ALU's HI/LO unit. Accepts a dividend/divisor pair on a start pulse, runs a restoring shift-subtract loop one quotient bit per clock, and returns a 64-bit result packed as {remainder, quotient} for the HI/LO registers. It sits beside the multiplier and is sequenced by the control unit through a start/done handshake.

---
 rtl/alu_pkg.sv | 18 +
 rtl/div_step.sv | 31 +++
 rtl/divider.sv | 118 +++++++++++
 tb/tb_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU HI/LO unit's sequential divider.
// Provides the operand width, the iteration count and the divider FSM state
// type, plus a small two's-complement magnitude helper.
package alu_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

  // Unsigned magnitude of a two's-complement value; the most negative value
  // maps onto itself, which read unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// Ports:
//   r      in   partial remainder (WIDTH+1 bits)
//   q      in   quotient/dividend shift register
//   dvsr   in   divisor magnitude
//   r_next out  partial remainder after this iteration
//   q_next out  shift register with the new quotient bit in bit 0
module div_step
  import alu_pkg::*;
(
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] trial;
  logic             neg;

  // {R,Q} shifted left by one: the dividend MSB moves into the remainder.
  assign sh    = {r, q[WIDTH-1]};
  // Extra headroom bit so the top bit of trial is a clean borrow flag.
  assign trial = sh - {2'b00, dvsr};
  assign neg   = trial[WIDTH+1];

  assign r_next = neg ? sh[WIDTH:0] : trial[WIDTH:0];
  assign q_next = {q[WIDTH-2:0], ~neg};

endmodule

// File: rtl/divider.sv
// Sequential signed divider for the HI/LO unit. Restoring shift-subtract on
// operand magnitudes, one quotient bit per clock, then sign correction so
// results match Verilog signed / and % (truncate toward zero, remainder takes
// the dividend's sign).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request, sampled only in IDLE
//   Dvnd, Dvsr   dividend / divisor, two's complement, held for the accept cycle
//   Y            {remainder, quotient}, registered, held until the next completion
//   busy         high from accept until the edge that raises done
//   done         one-cycle completion pulse
//   div_by_zero  set with done when the divisor was zero, held with Y
module divider
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   Dvnd,
  input  logic [WIDTH-1:0]   Dvsr,
  output logic [2*WIDTH-1:0] Y,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvsr_mag;
  logic             sign_q;
  logic             sign_r;
  logic             dbz_pend;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  div_step u_step (
    .r      (r_q),
    .q      (q_q),
    .dvsr   (dvsr_mag),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Negation wraps, so -2^31 / -1 naturally yields 0x8000_0000.
  assign quo_fix = sign_q ? (~q_q + 1'b1) : q_q;
  assign rem_fix = sign_r ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_mag    <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz_pend    <= 1'b0;
      Y           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvsr_mag <= mag(Dvsr);
            sign_q   <= Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1];
            sign_r   <= Dvnd[WIDTH-1];
            r_q      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            if (Dvsr == '0) begin
              // Raw dividend parked in Q so FIX can return it in the HI half.
              q_q      <= Dvnd;
              dbz_pend <= 1'b1;
              state    <= FIX;
            end else begin
              q_q      <= mag(Dvnd);
              dbz_pend <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) state <= FIX;
        end
        FIX: begin
          Y           <= dbz_pend ? {q_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
          div_by_zero <= dbz_pend;
          state       <= DONE;
        end
        DONE: begin
          // Two cycles here: the first raises done, the second drops it.
          // Staying in DONE while done is high keeps a start in that cycle
          // from being taken.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] Dvnd;
  logic [31:0] Dvsr;
  logic [63:0] Y;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Dvnd        (Dvnd),
    .Dvsr        (Dvsr),
    .Y           (Y),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: Verilog signed division semantics, plus the documented
  // divide-by-zero and overflow results.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Issue one start pulse and wait (bounded) for done. lat counts rising
  // edges from the accept edge to the edge that raised done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    Dvnd  = a;
    Dvsr  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    Dvnd  = $urandom;
    Dvsr  = $urandom;
    lat   = 1;
    chk("busy_after_accept", 64'(busy), 64'd1);
    while (!done && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_op(input logic [31:0] a, input logic [31:0] b);
    int lat;
    run_op(a, b, lat);
    chk("Y", Y, model(a, b));
    chk("div_by_zero", 64'(div_by_zero), (b == 32'd0) ? 64'd1 : 64'd0);
    chk("latency", 64'(lat), (b == 32'd0) ? 64'd3 : 64'd35);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] y_hold;
    logic [31:0] a, b;
    int lat;
    int sel;

    reset = 1'b1;
    start = 1'b0;
    Dvnd  = '0;
    Dvsr  = '0;
    #12;
    chk("reset_Y", Y, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    check_op(32'd100, 32'd7);
    check_op(-32'sd100, 32'd7);
    chk("neg_dividend_Y", Y, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    check_op(32'd100, -32'sd7);
    chk("neg_divisor_Y", Y, {32'd2, 32'hFFFF_FFF2});
    check_op(32'h8000_0000, 32'hFFFF_FFFF);
    chk("overflow_Y", Y, {32'h0, 32'h8000_0000});
    check_op(32'h8000_0000, 32'd1);
    check_op(32'd0, 32'd5);
    check_op(-32'sd7, -32'sd100);
    check_op(32'd5, 32'd0);
    chk("dbz_Y", Y, {32'd5, 32'hFFFF_FFFF});

    // div_by_zero held until the next op completes; a start during RUN is ignored.
    Dvnd  = 32'd100;
    Dvsr  = 32'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("dbz_held_mid_run", 64'(div_by_zero), 64'd1);
    chk("busy_mid_run", 64'(busy), 64'd1);
    Dvnd  = 32'd1;
    Dvsr  = 32'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat++;
    while (!done && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("done_seen_busy_start", 64'(done), 64'd1);
    chk("latency_busy_start", 64'(lat), 64'd35);
    chk("Y_busy_start", Y, {32'd2, 32'd14});
    chk("dbz_cleared", 64'(div_by_zero), 64'd0);
    // Start during the done cycle is ignored.
    y_hold = Y;
    Dvnd   = 32'd9;
    Dvsr   = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done_start", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("busy_still_idle", 64'(busy), 64'd0);
    chk("Y_unchanged", Y, y_hold);

    // Reset mid-operation aborts immediately.
    Dvnd  = 32'd1;
    Dvsr  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_Y", Y, 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 64'(done), 64'd0);
    check_op(32'd9, 32'd3);
    chk("after_abort_Y", Y, {32'd0, 32'd3});

    // Random signed pairs, biased toward edge operands.
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 7);
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      check_op(a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
